// File: rtl/result_bcd_pkg.sv
// Shared types and constants for the result-to-BCD converter.
package result_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD = 4'd3;

  // True when `digits` decimal digits can hold the largest `width`-bit value.
  function automatic bit digits_fit(int unsigned width, int unsigned digits);
    longint unsigned pow10;
    longint unsigned max_val;
    pow10 = 1;
    max_val = (64'd1 << width) - 64'd1;
    for (int unsigned i = 0; i < digits && pow10 <= max_val; i++) begin
      pow10 = pow10 * 10;
    end
    return pow10 > max_val;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble pre-shift correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import result_bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= ADJ_THRESH) begin
      digit_o = digit_i + ADJ_ADD;
    end
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter from engine result to packed BCD, with one pending slot.
// Optional leading-zero blank mask enabled by defining LEADING_ZERO_BLANK_EN.
module result_bcd_converter
  import result_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [WIDTH-1:0]        result_i,
  output logic [4*DIGITS-1:0]     bcd_o,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    overrun_o,
  output logic [DIGITS-1:0]       blank_o
);

  localparam int unsigned BcdW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned ShW  = BcdW + WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
    $error("result_bcd_converter: DIGITS too small to hold a WIDTH-bit value");
  end

  state_e            state_q;
  logic [ShW-1:0]    shift_q;
  logic [ShW-1:0]    shift_step;
  logic [BcdW-1:0]   adj_bcd;
  logic [BcdW-1:0]   final_bcd;
  logic [CntW-1:0]   cnt_q;
  logic [WIDTH-1:0]  pend_q;
  logic              pend_valid_q;
  logic [BcdW-1:0]   bcd_q;
  logic              done_q;
  logic              overrun_q;
  logic              in_valid;
  logic              last_step;

  // The engine holds its bus at zero except on the cycle a result is ready.
  assign in_valid = |result_i;
  assign last_step = (state_q == StShift) && (cnt_q == CntW'(1));

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i(shift_q[WIDTH + k*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o(adj_bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shift_step = {adj_bcd, shift_q[WIDTH-1:0]} << 1;
  assign final_bcd  = shift_step[ShW-1 -: BcdW];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      bcd_q        <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            shift_q <= {BcdW'(0), result_i};
            cnt_q   <= CntW'(WIDTH);
            state_q <= StShift;
          end
        end
        StShift: begin
          shift_q <= shift_step;
          cnt_q   <= cnt_q - 1'b1;
          if (last_step) begin
            bcd_q   <= final_bcd;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
          if (in_valid) begin
            if (!pend_valid_q) begin
              pend_q       <= result_i;
              pend_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (pend_valid_q) begin
            shift_q <= {BcdW'(0), pend_q};
            cnt_q   <= CntW'(WIDTH);
            state_q <= StShift;
            // The slot frees this edge, so a simultaneous arrival refills it.
            if (in_valid) begin
              pend_q <= result_i;
            end else begin
              pend_valid_q <= 1'b0;
            end
          end else if (in_valid) begin
            shift_q <= {BcdW'(0), result_i};
            cnt_q   <= CntW'(WIDTH);
            state_q <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;
  logic              blank_seen;

  always_comb begin
    blank_d    = '0;
    blank_seen = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      blank_seen = blank_seen | (final_bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W] != '0);
      blank_d[k] = !blank_seen;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      blank_q <= '0;
    end else if (last_step) begin
      blank_q <= blank_d;
    end
  end

  assign blank_o = blank_q;
`else
  assign blank_o = '0;
`endif

  assign bcd_o     = bcd_q;
  assign done_o    = done_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q == StShift) || (state_q == StDone);

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: vector table, directed timing sequences, random vs. decimal model.
// Expected blank_o follows LEADING_ZERO_BLANK_EN.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] result = '0;
  logic [19:0] bcd;
  logic        done;
  logic        busy;
  logic        overrun;
  logic [4:0]  blank;

  result_bcd_converter #(
    .WIDTH (16),
    .DIGITS(5)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .result_i (result),
    .bcd_o    (bcd),
    .done_o   (done),
    .busy_o   (busy),
    .overrun_o(overrun),
    .blank_o  (blank)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         cyc;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } done_t;

  typedef struct {
    logic [15:0] value;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec_t;

  done_t       dq[$];
  logic [15:0] sched[0:127];
  logic        busy_at[0:127];
  vec_t        vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_blank(input logic [4:0] b);
`ifdef LEADING_ZERO_BLANK_EN
    return b;
`else
    return b & 5'b0;
`endif
  endfunction

  function automatic logic [19:0] model_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digits beyond the decimal length of v are blank; digit 0 never is.
  function automatic logic [4:0] model_blank(input int unsigned v);
    logic [4:0] b;
    int unsigned x;
    int nd;
    x = v / 10;
    nd = 1;
    while (x != 0) begin
      nd++;
      x = x / 10;
    end
    b = '0;
    for (int k = 1; k < 5; k++) b[k] = (k >= nd);
    return exp_blank(b);
  endfunction

  // Apply sched[c] before edge c, record done events by edge index; clears sched afterwards.
  task automatic run(input int n);
    dq.delete();
    for (int c = 0; c < n; c++) begin
      result = sched[c];
      @(posedge clk);
      #1;
      busy_at[c] = busy;
      if (done) dq.push_back('{c, bcd, blank});
    end
    result = '0;
    for (int c = 0; c < 128; c++) sched[c] = '0;
  endtask

  task automatic check_done(input string name, input int idx, input int cyc,
                            input logic [19:0] exp_bcd, input logic [4:0] exp_bl);
    if (dq.size() <= idx) begin
      check({name, "_present"}, 64'(dq.size()), 64'(idx + 1));
    end else begin
      check({name, "_cycle"}, 64'(dq[idx].cyc), 64'(cyc));
      check({name, "_bcd"}, 64'(dq[idx].bcd), 64'(exp_bcd));
      check({name, "_blank"}, 64'(dq[idx].blank), 64'(exp_bl));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    int unsigned b;
    int g;
    int start2;

    for (int c = 0; c < 128; c++) sched[c] = '0;
    vecs[0] = '{16'd5,     20'h00005, 5'b11110};
    vecs[1] = '{16'd235,   20'h00235, 5'b11000};
    vecs[2] = '{16'd8132,  20'h08132, 5'b10000};
    vecs[3] = '{16'd65535, 20'h65535, 5'b00000};
    vecs[4] = '{16'd10,    20'h00010, 5'b11100};
    vecs[5] = '{16'd1,     20'h00001, 5'b11110};
    vecs[6] = '{16'd40000, 20'h40000, 5'b00000};

    // Reset state.
    @(posedge clk);
    #1;
    check("reset_bcd", 64'(bcd), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_overrun", 64'(overrun), 64'h0);
    check("reset_blank", 64'(blank), 64'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table: single result, done exactly 16 edges after sampling.
    foreach (vecs[i]) begin
      sched[0] = vecs[i].value;
      run(20);
      check($sformatf("vec%0d_count", i), 64'(dq.size()), 64'd1);
      check_done($sformatf("vec%0d", i), 0, 16, vecs[i].bcd, exp_blank(vecs[i].blank));
      check($sformatf("vec%0d_busy_first", i), 64'(busy_at[0]), 64'd1);
      check($sformatf("vec%0d_busy_done", i), 64'(busy_at[16]), 64'd1);
      check($sformatf("vec%0d_busy_after", i), 64'(busy_at[17]), 64'd0);
    end

    // 235 then 8132 three cycles later: second comes out of the pending slot.
    sched[0] = 16'd235;
    sched[3] = 16'd8132;
    run(40);
    check("pair_count", 64'(dq.size()), 64'd2);
    check_done("pair_first", 0, 16, 20'h00235, exp_blank(5'b11000));
    check_done("pair_second", 1, 33, 20'h08132, exp_blank(5'b10000));
    check("pair_overrun", 64'(overrun), 64'd0);

    // Random pairs: second starts at its arrival or the DONE edge, whichever is later.
    for (int t = 0; t < 10; t++) begin
      a = $urandom_range(1, 65535);
      b = $urandom_range(1, 65535);
      g = int'($urandom_range(1, 25));
      start2 = (g > 17) ? g : 17;
      sched[0] = 16'(a);
      sched[g] = 16'(b);
      run(start2 + 20);
      check($sformatf("rpair%0d_count", t), 64'(dq.size()), 64'd2);
      check_done($sformatf("rpair%0d_a", t), 0, 16, model_bcd(a), model_blank(a));
      check_done($sformatf("rpair%0d_b", t), 1, start2 + 16, model_bcd(b), model_blank(b));
      check($sformatf("rpair%0d_overrun", t), 64'(overrun), 64'd0);
    end

    // Random singles against the decimal model.
    for (int t = 0; t < 20; t++) begin
      a = $urandom_range(1, 65535);
      sched[0] = 16'(a);
      run(19);
      check($sformatf("rand%0d_count", t), 64'(dq.size()), 64'd1);
      check_done($sformatf("rand%0d", t), 0, 16, model_bcd(a), model_blank(a));
    end

    // DONE with pending full and a new arrival: new value takes the freed slot.
    sched[0]  = 16'd1234;
    sched[3]  = 16'd999;
    sched[17] = 16'd777;
    run(56);
    check("refill_count", 64'(dq.size()), 64'd3);
    check_done("refill_a", 0, 16, 20'h01234, exp_blank(5'b10000));
    check_done("refill_b", 1, 33, 20'h00999, exp_blank(5'b11000));
    check_done("refill_c", 2, 50, 20'h00777, exp_blank(5'b11000));
    check("refill_overrun", 64'(overrun), 64'd0);

    // Three results three cycles apart: third is dropped, overrun sticks.
    sched[0] = 16'd111;
    sched[3] = 16'd222;
    sched[6] = 16'd333;
    run(60);
    check("drop_count", 64'(dq.size()), 64'd2);
    check_done("drop_a", 0, 16, 20'h00111, exp_blank(5'b11000));
    check_done("drop_b", 1, 33, 20'h00222, exp_blank(5'b11000));
    check("drop_overrun", 64'(overrun), 64'd1);
    sched[0] = 16'd42;
    run(20);
    check("drop_overrun_sticky", 64'(overrun), 64'd1);
    do_reset();
    check("drop_overrun_cleared", 64'(overrun), 64'd0);

    // Reset during SHIFT aborts; nothing partial reaches bcd.
    sched[0] = 16'd5;
    run(20);
    check("abort_pre_bcd", 64'(bcd), 64'h00005);
    sched[0] = 16'd235;
    run(9);
    reset_n = 1'b0;
    #1;
    check("abort_bcd", 64'(bcd), 64'h0);
    check("abort_done", 64'(done), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_overrun", 64'(overrun), 64'h0);
    check("abort_blank", 64'(blank), 64'h0);
    #3;
    reset_n = 1'b1;
    run(30);
    check("abort_no_done", 64'(dq.size()), 64'd0);
    check("abort_bcd_after", 64'(bcd), 64'h0);
    check("abort_busy_after", 64'(busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Downstream of the difference engine: consumes its 16-bit `f_of_n` result and converts it to packed BCD for the seven-segment display stage.
- The engine drives its result bus non-zero for exactly one cycle per computation and 0 otherwise, so a non-zero input is treated as a valid strobe.
- Conversion is sequential double-dabble (add-3 then shift), one bit per clock, with a one-deep pending buffer so back-to-back results are not lost.

Parameters:
- WIDTH, 16, binary input width.
- DIGITS, 5, BCD digit count; must satisfy 10^DIGITS > 2^WIDTH-1 (checked by elaboration assertion).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- reset_n_i  input  1  asynchronous active-low reset.
- result_i  input  WIDTH  engine result; non-zero = valid sample this cycle.
- bcd_o  output  4*DIGITS  packed BCD; digit 0 in bits [3:0]; holds last completed conversion.
- done_o  output  1  one-cycle pulse when bcd_o updates.
- busy_o  output  1  high in SHIFT and DONE states.
- overrun_o  output  1  sticky; a result was dropped.
- blank_o  output  DIGITS  leading-zero blank mask (see Optional Feature).

Behaviour:
- Reset (async, reset_n_i low): state IDLE; bcd_o=0, done_o=0, busy_o=0, overrun_o=0, blank_o=0; pending buffer empty; shift register and counter cleared.
- Reset mid-conversion aborts immediately. No partial result reaches bcd_o.
- IDLE:
  - result_i!=0 at edge E0 loads shifter {bcd=0, bin=result_i}, cnt=WIDTH, goes to SHIFT.
  - result_i==0 stays in IDLE.
- SHIFT, one step per cycle:
  - Every BCD digit >=5 gets +3 (4-bit, no carry between digits).
  - Then {bcd,bin} shifts left by 1 and cnt decrements.
  - The step that takes cnt to 0 also registers the final BCD into bcd_o and goes to DONE.
- Latency: sampled at E0; last shift at edge E0+WIDTH; done_o high in the cycle after that edge (16 edges for the default WIDTH).
- DONE (one cycle):
  - done_o=1.
  - If pending valid: load pending into shifter, clear pending, go to SHIFT.
  - Else if result_i!=0: load result_i directly, go to SHIFT.
  - Else go to IDLE.
- Arrival while busy (SHIFT, or DONE with the shifter already taking pending):
  - Pending empty: store result_i in pending.
  - Pending full: drop result_i and set overrun_o. overrun_o clears only on reset.
- Simultaneous DONE + pending + new result_i: pending goes to shifter; result_i is written into the now-free pending slot; no overrun.
- bcd_o changes only at the final-shift edge, so it is stable between done_o pulses.
- result_i == 0 is never converted (the engine never produces 0 as a valid result; minimum f=5).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: blank_o[k]=1 for every digit k above the most significant non-zero digit, registered together with bcd_o. Digit 0 is never blanked. Example: value 235 gives blank_o=5'b11000.
- Undefined: blank_o tied to 0 and no extra logic.

Decomposition:
- Shared package result_bcd_pkg:
  - state enum {IDLE, SHIFT, DONE} as a 2-bit logic typedef.
  - BCD_DIGIT_W=4 constant.
  - ADJ_THRESH=5 and ADJ_ADD=3 constants.
- Sub-module bcd_digit_adjust: combinational per-digit add-3, instantiated DIGITS times via generate.

Test Plan:
- Reset then single result_i=16'd5 for 1 cycle → done_o pulse exactly 16 edges after sampling edge; bcd_o=20'h00005; busy_o low the cycle after.
- result_i=235 (n=10) then result_i=8132 (n=63) 3 cycles later → first done bcd_o=20'h00235, second immediately follows from pending, bcd_o=20'h08132; overrun_o=0.
- result_i=65535 → bcd_o=20'h65535 (max width, all digits adjusted).
- Three results 3 cycles apart during one conversion → first two converted in order, third dropped, overrun_o=1 and stays 1 until reset.
- Assert reset_n_i low at SHIFT cycle 8 of converting 235 → all outputs 0 immediately; after release, bcd_o stays 0 and there is no done_o.
- With LEADING_ZERO_BLANK_EN: 235 → blank_o=5'b11000; 5 → 5'b11110. Without the macro: blank_o=0 for both.
